// File: rtl/fpu_pkg.sv
// fpu_pkg: shared opcodes, command bundle, sequencer states and
// the legal-opcode test used by the FP issue controller.
package fpu_pkg;

  localparam logic [5:0] OP_NOP = 6'b000000;
  localparam logic [5:0] OP_SW  = 6'b001011;
  localparam logic [5:0] OP_ADD = 6'b110000;
  localparam logic [5:0] OP_SUB = 6'b110001;
  localparam logic [5:0] OP_MUL = 6'b110010;
  localparam logic [5:0] OP_DIV = 6'b110011;
  localparam logic [5:0] OP_CMP = 6'b110100;
  localparam logic [5:0] OP_RCP = 6'b110101;
  localparam logic [5:0] OP_RND = 6'b110110;

  typedef struct packed {
    logic        is_load;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] wdata;
  } fpu_cmd_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_GAP,
    S_RESP
  } fpu_state_t;

  function automatic logic is_legal_op(input logic [5:0] op);
    return (op == OP_SW) || ((op >= OP_ADD) && (op <= OP_RND));
  endfunction

endpackage

// File: rtl/fpu_cmd_fifo.sv
// fpu_cmd_fifo: DEPTH-entry command queue with flush.
// Ports: push/din in, pop/dout out (head), full/empty flags.
module fpu_cmd_fifo
  import fpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  logic     pop,
  input  logic     flush,
  input  fpu_cmd_t din,
  output fpu_cmd_t dout,
  output logic     full,
  output logic     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  fpu_cmd_t    mem [DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  // Flush wins over push and pop at the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full && !flush)
      mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: queues FP commands and sequences them onto the
// coprocessor cp_* bus; retries on cp_cache_done, gaps after div/rcp,
// returns sw data on resp_*; busy/err_illegal status.
module fpu_issue_ctrl
  import fpu_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int DIV_GAP = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_load,
  input  logic [5:0]  req_opcode,
  input  logic [4:0]  req_rs,
  input  logic [4:0]  req_rt,
  input  logic [4:0]  req_rd,
  input  logic [31:0] req_wdata,
  input  logic        flush,
  output logic [5:0]  cp_opcode,
  output logic [4:0]  cp_rs,
  output logic [4:0]  cp_rt,
  output logic [4:0]  cp_rd,
  output logic [4:0]  cp_waddr,
  output logic [31:0] cp_wdata,
  output logic        cp_we,
  input  logic        cp_cache_done,
  input  logic [31:0] cp_outdata,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        busy,
  output logic        err_illegal
);

  localparam int GW = (DIV_GAP > 1) ? $clog2(DIV_GAP) : 1;
  localparam logic [GW-1:0] GAP_INIT =
    GW'((DIV_GAP > 0) ? DIV_GAP - 1 : 0);

  fpu_state_t    state;
  logic [GW-1:0] gap_cnt;

  fpu_cmd_t req_cmd;
  fpu_cmd_t head;
  logic     full;
  logic     empty;
  logic     push;
  logic     dispatch;
  logic     head_ok;
  logic     cur_sw;
  logic     cur_long;
  logic     issue_done;

  assign req_cmd = '{
    is_load: req_is_load,
    opcode:  req_opcode,
    rs:      req_rs,
    rt:      req_rt,
    rd:      req_rd,
    wdata:   req_wdata
  };

  assign req_ready = !full;
  assign push      = req_valid && !full && !flush;
  assign busy      = !empty || (state != S_IDLE);

  assign cur_sw     = (cp_opcode == OP_SW);
  assign cur_long   = ((cp_opcode == OP_DIV) || (cp_opcode == OP_RCP)) &&
                      (DIV_GAP > 0);
  assign issue_done = (state == S_ISSUE) && !cp_cache_done;
  assign head_ok    = head.is_load || is_legal_op(head.opcode);

  // The head is taken from IDLE, straight after a plain command
  // executes (back-to-back), or when the post-div gap expires so the
  // gap is exactly DIV_GAP bus cycles.
  assign dispatch = !empty && !flush && (
    (state == S_IDLE) ||
    (issue_done && !cur_sw && !cur_long) ||
    ((state == S_GAP) && (gap_cnt == '0)));

  fpu_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (dispatch),
    .flush (flush),
    .din   (req_cmd),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      gap_cnt     <= '0;
      cp_opcode   <= OP_NOP;
      cp_rs       <= '0;
      cp_rt       <= '0;
      cp_rd       <= '0;
      cp_waddr    <= '0;
      cp_wdata    <= '0;
      cp_we       <= 1'b0;
      resp_valid  <= 1'b0;
      resp_data   <= '0;
      err_illegal <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
        end
        S_ISSUE: begin
          // A stalled command keeps the bus unchanged for the retry.
          if (!cp_cache_done) begin
            cp_opcode <= OP_NOP;
            cp_we     <= 1'b0;
            if (cur_sw) begin
              state <= S_RESP;
            end else if (cur_long) begin
              state   <= S_GAP;
              gap_cnt <= GAP_INIT;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == '0)
            state <= S_IDLE;
          else
            gap_cnt <= gap_cnt - 1'b1;
        end
        S_RESP: begin
          resp_data  <= cp_outdata;
          resp_valid <= 1'b1;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      // Overrides the case above; illegal heads vanish without a bus cycle.
      if (dispatch) begin
        if (head_ok) begin
          state     <= S_ISSUE;
          cp_opcode <= head.is_load ? OP_NOP : head.opcode;
          cp_we     <= head.is_load;
          cp_rs     <= head.rs;
          cp_rt     <= head.rt;
          cp_rd     <= head.rd;
          cp_waddr  <= head.rd;
          cp_wdata  <= head.wdata;
        end else begin
          err_illegal <= 1'b1;
          state       <= S_IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb_fpu_issue_ctrl: directed checks of the FP issue controller
// against a small behavioural coprocessor.
module tb_fpu_issue_ctrl;
  import fpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_load;
  logic [5:0]  req_opcode;
  logic [4:0]  req_rs;
  logic [4:0]  req_rt;
  logic [4:0]  req_rd;
  logic [31:0] req_wdata;
  logic        flush;
  logic [5:0]  cp_opcode;
  logic [4:0]  cp_rs;
  logic [4:0]  cp_rt;
  logic [4:0]  cp_rd;
  logic [4:0]  cp_waddr;
  logic [31:0] cp_wdata;
  logic        cp_we;
  logic        cp_cache_done;
  logic [31:0] cp_outdata = '0;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        busy;
  logic        err_illegal;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fpu_issue_ctrl #(
    .DEPTH   (4),
    .DIV_GAP (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_is_load   (req_is_load),
    .req_opcode    (req_opcode),
    .req_rs        (req_rs),
    .req_rt        (req_rt),
    .req_rd        (req_rd),
    .req_wdata     (req_wdata),
    .flush         (flush),
    .cp_opcode     (cp_opcode),
    .cp_rs         (cp_rs),
    .cp_rt         (cp_rt),
    .cp_rd         (cp_rd),
    .cp_waddr      (cp_waddr),
    .cp_wdata      (cp_wdata),
    .cp_we         (cp_we),
    .cp_cache_done (cp_cache_done),
    .cp_outdata    (cp_outdata),
    .resp_valid    (resp_valid),
    .resp_data     (resp_data),
    .busy          (busy),
    .err_illegal   (err_illegal)
  );

  // Coprocessor: executes whatever is on the bus at a non-stalled edge.
  logic [31:0] regs [32];
  int exec_cnt = 0;
  always @(posedge clk) begin
    if (!rst && !cp_cache_done) begin
      if (cp_we)
        regs[cp_waddr] <= cp_wdata;
      if (cp_opcode == OP_SW)
        cp_outdata <= regs[cp_rt];
      if (cp_we || cp_opcode != OP_NOP)
        exec_cnt <= exec_cnt + 1;
    end
  end

  logic [5:0] trace [$];
  logic       we_q [$];
  int         resp_cnt = 0;
  always @(negedge clk) begin
    trace.push_back(cp_opcode);
    we_q.push_back(cp_we);
    if (resp_valid)
      resp_cnt++;
  end

  function automatic int find_op(input logic [5:0] op);
    for (int k = 0; k < trace.size(); k++)
      if (trace[k] == op)
        return k;
    return -1;
  endfunction

  function automatic int count_op(input logic [5:0] op);
    int c = 0;
    for (int k = 0; k < trace.size(); k++)
      if (trace[k] == op)
        c++;
    return c;
  endfunction

  task automatic push_cmd(input logic ld, input logic [5:0] op,
                          input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [31:0] wd);
    req_valid   = 1'b1;
    req_is_load = ld;
    req_opcode  = op;
    req_rs      = rs;
    req_rt      = rt;
    req_rd      = rd;
    req_wdata   = wd;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (busy && n < max) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL wait_idle busy still %b after %0d cycles, want 0", busy, max);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b0;
    req_is_load = 1'b0;
    req_opcode = OP_NOP;
    req_rs = '0;
    req_rt = '0;
    req_rd = '0;
    req_wdata = '0;
    flush = 1'b0;
    cp_cache_done = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (cp_opcode !== OP_NOP || cp_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_cp opcode %h we %b, want 00 0", cp_opcode, cp_we);
    end
    checks++;
    if ({cp_rs, cp_rt, cp_rd, cp_waddr, cp_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_cp_addr got %h, want 0",
               {cp_rs, cp_rt, cp_rd, cp_waddr, cp_wdata});
    end
    checks++;
    if (busy !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_flags busy %b ready %b, want 0 1", busy, req_ready);
    end
    checks++;
    if (resp_valid !== 1'b0 || resp_data !== 32'h0 || err_illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset_resp valid %b data %h err %b, want 0 0 0",
               resp_valid, resp_data, err_illegal);
    end
  endtask

  task automatic test_reset_mid_issue();
    int e0;
    int n = 0;
    cp_cache_done = 1'b1;
    push_cmd(1'b0, OP_ADD, 5'd1, 5'd2, 5'd3, 32'h0);
    while (cp_opcode !== OP_ADD && n < 8) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cp_opcode !== OP_ADD) begin
      errors++;
      $display("FAIL rst_mid_reach cp_opcode %h, want %h", cp_opcode, OP_ADD);
    end
    e0 = exec_cnt;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (cp_opcode !== OP_NOP || cp_we !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_cp opcode %h we %b, want 00 0", cp_opcode, cp_we);
    end
    checks++;
    if (busy !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_flags busy %b ready %b, want 0 1", busy, req_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    cp_cache_done = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (exec_cnt != e0) begin
      errors++;
      $display("FAIL rst_mid_abort executed %0d, want 0", exec_cnt - e0);
    end
  endtask

  task automatic test_back_to_back();
    int i;
    int e0 = exec_cnt;
    trace.delete();
    push_cmd(1'b0, OP_ADD, 5'd1, 5'd2, 5'd3, 32'h0);
    push_cmd(1'b0, OP_MUL, 5'd1, 5'd2, 5'd4, 32'h0);
    repeat (4) @(negedge clk);
    i = find_op(OP_ADD);
    checks++;
    if (i < 0 || i + 2 >= trace.size()) begin
      errors++;
      $display("FAIL b2b_add_seen index %0d, want add on bus", i);
    end else begin
      checks++;
      if (trace[i+1] !== OP_MUL) begin
        errors++;
        $display("FAIL b2b_next got %h, want %h", trace[i+1], OP_MUL);
      end
      checks++;
      if (trace[i+2] !== OP_NOP || count_op(OP_ADD) != 1) begin
        errors++;
        $display("FAIL b2b_single after %h add_cycles %0d, want 00 1",
                 trace[i+2], count_op(OP_ADD));
      end
    end
    checks++;
    if (exec_cnt - e0 != 2) begin
      errors++;
      $display("FAIL b2b_exec got %0d, want 2", exec_cnt - e0);
    end
  endtask

  task automatic test_retry();
    int e0 = exec_cnt;
    int n = 0;
    trace.delete();
    cp_cache_done = 1'b1;
    push_cmd(1'b0, OP_ADD, 5'd7, 5'd8, 5'd9, 32'h0);
    while (cp_opcode !== OP_ADD && n < 8) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    cp_cache_done = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (count_op(OP_ADD) != 4) begin
      errors++;
      $display("FAIL retry_hold add cycles %0d, want 4", count_op(OP_ADD));
    end
    checks++;
    if (exec_cnt - e0 != 1) begin
      errors++;
      $display("FAIL retry_exec got %0d, want 1", exec_cnt - e0);
    end
    checks++;
    if ({cp_rs, cp_rt, cp_rd} !== {5'd7, 5'd8, 5'd9}) begin
      errors++;
      $display("FAIL retry_regs got %0d %0d %0d, want 7 8 9", cp_rs, cp_rt, cp_rd);
    end
  endtask

  task automatic test_load_sw();
    int wes = 0;
    trace.delete();
    we_q.delete();
    resp_cnt = 0;
    push_cmd(1'b1, OP_NOP, 5'd0, 5'd0, 5'd5, 32'h3F80_0000);
    push_cmd(1'b0, OP_SW, 5'd0, 5'd5, 5'd0, 32'h0);
    wait_idle(20);
    foreach (we_q[k])
      if (we_q[k] === 1'b1)
        wes++;
    checks++;
    if (wes != 1) begin
      errors++;
      $display("FAIL load_we cycles %0d, want 1", wes);
    end
    checks++;
    if (resp_cnt != 1) begin
      errors++;
      $display("FAIL sw_pulses got %0d, want 1", resp_cnt);
    end
    checks++;
    if (resp_data !== 32'h3F80_0000) begin
      errors++;
      $display("FAIL sw_data got %h, want 3f800000", resp_data);
    end
  endtask

  task automatic test_div_gap();
    int i;
    trace.delete();
    push_cmd(1'b0, OP_DIV, 5'd1, 5'd2, 5'd6, 32'h0);
    push_cmd(1'b0, OP_ADD, 5'd1, 5'd2, 5'd7, 32'h0);
    wait_idle(20);
    i = find_op(OP_DIV);
    checks++;
    if (i < 0 || i + 3 >= trace.size()) begin
      errors++;
      $display("FAIL gap_div_seen index %0d, want div on bus", i);
    end else begin
      checks++;
      if (trace[i+1] !== OP_NOP || trace[i+2] !== OP_NOP) begin
        errors++;
        $display("FAIL gap_nops got %h %h, want 00 00", trace[i+1], trace[i+2]);
      end
      checks++;
      if (trace[i+3] !== OP_ADD) begin
        errors++;
        $display("FAIL gap_next got %h, want %h", trace[i+3], OP_ADD);
      end
    end
  endtask

  task automatic test_full_flush();
    int e0 = exec_cnt;
    trace.delete();
    cp_cache_done = 1'b1;
    push_cmd(1'b0, OP_ADD, 5'd1, 5'd1, 5'd1, 32'h0);
    repeat (4) push_cmd(1'b0, OP_MUL, 5'd2, 5'd2, 5'd2, 32'h0);
    checks++;
    if (req_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL full_ready ready %b busy %b, want 0 1", req_ready, busy);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL flush_ready ready %b busy %b, want 1 1", req_ready, busy);
    end
    flush = 1'b1;
    push_cmd(1'b0, OP_SUB, 5'd3, 5'd3, 5'd3, 32'h0);
    flush = 1'b0;
    cp_cache_done = 1'b0;
    wait_idle(20);
    checks++;
    if (exec_cnt - e0 != 1) begin
      errors++;
      $display("FAIL flush_exec got %0d, want 1", exec_cnt - e0);
    end
    checks++;
    if (find_op(OP_MUL) >= 0 || find_op(OP_SUB) >= 0) begin
      errors++;
      $display("FAIL flush_dropped mul_at %0d sub_at %0d, want -1 -1",
               find_op(OP_MUL), find_op(OP_SUB));
    end
  endtask

  task automatic test_illegal();
    int e0 = exec_cnt;
    trace.delete();
    checks++;
    if (err_illegal !== 1'b0) begin
      errors++;
      $display("FAIL illegal_pre got %b, want 0", err_illegal);
    end
    push_cmd(1'b0, 6'b111111, 5'd1, 5'd2, 5'd3, 32'h0);
    push_cmd(1'b0, OP_CMP, 5'd1, 5'd2, 5'd3, 32'h0);
    wait_idle(20);
    checks++;
    if (err_illegal !== 1'b1) begin
      errors++;
      $display("FAIL illegal_flag got %b, want 1", err_illegal);
    end
    checks++;
    if (find_op(6'b111111) >= 0 || exec_cnt - e0 != 1) begin
      errors++;
      $display("FAIL illegal_bus at %0d exec %0d, want -1 1",
               find_op(6'b111111), exec_cnt - e0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_reset_mid_issue();
    test_back_to_back();
    test_retry();
    test_load_sw();
    test_div_gap();
    test_full_flush();
    test_illegal();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
